// File: rtl/state_timer.sv
// -----------------------------------------------------------------------------
// state_timer
//
// Seconds timer that paces the traffic-light controller. It captures the
// duration (in seconds) that the controller publishes for its current state,
// counts it down from the system clock and then pulses `finished` for one
// cycle so the controller advances and publishes the next duration.
//
// Sequence: IDLE -> FIRE -> LOAD -> COUNT -> FIRE -> LOAD -> ...
//   FIRE  : `finished` is high; the controller moves on at its closing edge.
//   LOAD  : the new duration is captured (a zero duration fires again).
//   COUNT : a prescaler divides the clock down to one-second steps.
//
// Parameters
//   CLK_HZ : clock cycles per second (10000 in the system, small in benches)
//   PRE_W  : prescaler width, 2**PRE_W must be >= CLK_HZ
//
// Ports
//   clk            : system clock
//   reset          : asynchronous, active-low; clears all state
//   enable         : system enable; low forces IDLE at the next edge
//   secondsToCount : duration of the controller's current state, seconds
//   finished       : one-cycle pulse, current duration has elapsed
//   seconds_left   : whole seconds remaining, for display
//   tick_1hz       : one-cycle pulse after each elapsed second
// -----------------------------------------------------------------------------
module state_timer #(
    parameter int CLK_HZ = 10000,
    parameter int PRE_W  = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] secondsToCount,
    output logic        finished,
    output logic [15:0] seconds_left,
    output logic        tick_1hz
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_COUNT = 2'd3
    } state_t;

    // Terminal prescaler value; the compare is an exact equality.
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [15:0]        rem_q, rem_d;
    logic [15:0]        seconds_left_q, seconds_left_d;
    logic               finished_q, finished_d;
    logic               tick_q, tick_d;

    // One full second has elapsed in this COUNT cycle.
    logic               wrap;

    assign wrap = (state_q == ST_COUNT) && (pre_q == PRE_MAX);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pre_q          <= '0;
            rem_q          <= '0;
            seconds_left_q <= '0;
            finished_q     <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            rem_q          <= rem_d;
            seconds_left_q <= seconds_left_d;
            finished_q     <= finished_d;
            tick_q         <= tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Dropping enable overrides every other transition.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FIRE;
                ST_FIRE: state_d = ST_LOAD;
                ST_LOAD: begin
                    // A zero duration completes immediately.
                    if (secondsToCount == 16'd0) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Last second elapsing; "<= 1" also guards against a
                    // remaining count that is somehow already zero.
                    if (wrap && (rem_q <= 16'd1)) begin
                        state_d = ST_FIRE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output and datapath next values. Outputs are registered, so `finished`
    // is driven from the state being entered rather than the current one.
    // -------------------------------------------------------------------------
    always_comb begin
        pre_d          = pre_q;
        rem_d          = rem_q;
        seconds_left_d = seconds_left_q;
        tick_d         = 1'b0;
        finished_d     = (state_d == ST_FIRE);

        if (!enable) begin
            pre_d          = '0;
            rem_d          = '0;
            seconds_left_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pre_d          = '0;
                    rem_d          = '0;
                    seconds_left_d = '0;
                end
                ST_FIRE: begin
                    // Hold: the controller is switching its duration now.
                end
                ST_LOAD: begin
                    pre_d          = '0;
                    rem_d          = secondsToCount;
                    seconds_left_d = secondsToCount;
                end
                ST_COUNT: begin
                    if (wrap) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        // Saturate at zero rather than wrap to 0xFFFF.
                        if (rem_q != 16'd0) begin
                            rem_d          = rem_q - 16'd1;
                            seconds_left_d = rem_q - 16'd1;
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
                default: begin
                    pre_d          = '0;
                    rem_d          = '0;
                    seconds_left_d = '0;
                end
            endcase
        end
    end

    assign finished     = finished_q;
    assign seconds_left = seconds_left_q;
    assign tick_1hz     = tick_q;

endmodule

// File: tb/tb_state_timer.sv
// -----------------------------------------------------------------------------
// tb_state_timer
//
// Drives state_timer with CLK_HZ=4. A period-based reference model predicts
// every output on every cycle: after a FIRE cycle comes the LOAD cycle, then
// N*CLK_HZ counting cycles, so position t inside a period determines the
// outputs directly. Directed scenarios add literal expectations, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_state_timer;

    localparam int C = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] stc;
    logic        finished;
    logic [15:0] seconds_left;
    logic        tick_1hz;

    state_timer #(.CLK_HZ(C), .PRE_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .secondsToCount (stc),
        .finished       (finished),
        .seconds_left   (seconds_left),
        .tick_1hz       (tick_1hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: position t within the current period.
    //   t = 0          : FIRE cycle
    //   t = 1          : LOAD cycle
    //   t = 2 + k      : k-th counting cycle, k < n*C
    // ------------------------------------------------------------------
    bit  m_active = 0;
    int  m_t      = 0;
    int  m_n      = 0;
    bit  m_fire_tick = 0;
    int  e_fin, e_sl, e_tick;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0;
        end else begin
            cyc++;
            if (!enable) begin
                m_active = 0;
            end else if (!m_active) begin
                m_active    = 1;
                m_t         = 0;
                m_fire_tick = 0;
            end else begin
                if (m_t == 1) m_n = int'(stc);
                m_t++;
                if (m_t == m_n * C + 2) begin
                    m_t         = 0;
                    m_fire_tick = (m_n != 0);
                end
            end
        end

        if (!reset || !m_active) begin
            e_fin = 0; e_sl = 0; e_tick = 0;
        end else if (m_t == 0) begin
            e_fin = 1; e_sl = 0; e_tick = int'(m_fire_tick);
        end else if (m_t == 1) begin
            e_fin = 0; e_sl = 0; e_tick = 0;
        end else begin
            e_fin  = 0;
            e_sl   = m_n - (m_t - 2) / C;
            e_tick = ((m_t - 2) != 0 && (m_t - 2) % C == 0) ? 1 : 0;
        end

        #2;
        check("model_finished",     {31'd0, finished},     e_fin);
        check("model_seconds_left", {16'd0, seconds_left}, e_sl);
        check("model_tick_1hz",     {31'd0, tick_1hz},     e_tick);
    end

    // Wait (bounded) for the next finished pulse, observed at a negedge.
    task automatic next_fin(input int maxc, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (finished === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL next_fin_timeout: no finished within %0d cycles (cycle %0d)", maxc, cyc);
            at = cyc;
        end
    endtask

    int durs [11] = '{17, 3, 1, 55, 3, 1, 27, 3, 1, 24, 3};
    int gaps [11] = '{70, 14, 6, 222, 14, 6, 110, 14, 6, 98, 14};

    initial begin
        int r, t_prev, t_now;

        reset  = 1'b0;
        enable = 1'b1;
        stc    = 16'd17;
        repeat (3) @(negedge clk);

        // ---- Startup ----
        reset = 1'b1;
        r = cyc;
        @(negedge clk);
        check("startup_finished", {31'd0, finished}, 1);
        check("startup_cycle", cyc - r, 1);
        t_prev = cyc;
        repeat (2) @(negedge clk);
        check("load_17", {16'd0, seconds_left}, 17);
        repeat (4) @(negedge clk);
        check("first_second_16", {16'd0, seconds_left}, 16);

        // ---- Closed loop: bench acts as the controller ----
        for (int i = 0; i < 11; i++) begin
            next_fin(400, t_now);
            check($sformatf("loop_gap_%0d", i), t_now - t_prev, gaps[i]);
            t_prev = t_now;
            if (i < 10) stc = 16'(durs[i + 1]);
        end

        // ---- Input change outside LOAD ----
        stc = 16'd3;
        repeat (6) @(negedge clk);
        stc = 16'd9;
        next_fin(100, t_now);
        check("ignore_change_gap", t_now - t_prev, 3 * C + 2);
        t_prev = t_now;
        next_fin(100, t_now);
        check("captured_9_gap", t_now - t_prev, 9 * C + 2);
        t_prev = t_now;

        // ---- Zero duration ----
        stc = 16'd0;
        for (int i = 0; i < 3; i++) begin
            next_fin(10, t_now);
            check($sformatf("zero_gap_%0d", i), t_now - t_prev, 2);
            check("zero_tick", {31'd0, tick_1hz}, 0);
            check("zero_seconds_left", {16'd0, seconds_left}, 0);
            t_prev = t_now;
        end

        // ---- Enable drop at prescaler=2, remaining=5 ----
        stc = 16'd5;
        repeat (4) @(negedge clk);
        check("pre_drop_seconds_left", {16'd0, seconds_left}, 5);
        enable = 1'b0;
        @(negedge clk);
        check("drop_finished", {31'd0, finished}, 0);
        check("drop_seconds_left", {16'd0, seconds_left}, 0);
        check("drop_tick", {31'd0, tick_1hz}, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_finished", {31'd0, finished}, 1);
        stc = 16'd2;

        // ---- Asynchronous reset mid-count ----
        repeat (3) @(negedge clk);
        check("pre_reset_seconds_left", {16'd0, seconds_left}, 2);
        reset = 1'b0;
        #1;
        check("async_seconds_left", {16'd0, seconds_left}, 0);
        check("async_finished", {31'd0, finished}, 0);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("recover_finished", {31'd0, finished}, 1);

        // ---- Randomized phase, checked by the model every cycle ----
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) stc = 16'($urandom_range(0, 3));
            if (!enable) begin
                if ($urandom_range(0, 2) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                enable = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #3;
                reset = 1'b1;
            end
        end

        enable = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
